// File: rtl/inout_sram_port_ctrl.sv
// Port controller for the dual-port InOut activation SRAM: port A takes a write stream,
// port B serves read requests whose data returns through a 2-entry skid buffer.
module inout_sram_port_ctrl #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] sram_a_addr,
    output logic [DATA_W-1:0] sram_a_di,
    output logic              sram_a_cs,
    output logic              sram_a_wen,
    output logic              sram_a_oe,
    output logic [ADDR_W-1:0] sram_b_addr,
    output logic [DATA_W-1:0] sram_b_di,
    output logic              sram_b_cs,
    output logic              sram_b_wen,
    output logic              sram_b_oe,
    input  logic [DATA_W-1:0] sram_b_do,
    output logic [15:0]       conflict_cnt,
    output logic              idle
);

    logic              inflight_q, inflight_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] fifo_mem_q [2];
    logic [DATA_W-1:0] fifo_mem_d [2];
    logic [15:0]       conflict_cnt_q, conflict_cnt_d;

    logic wr_fire;
    logic conflict;
    logic rd_fire;
    logic fifo_empty;
    logic pop;
    logic pop_fifo;
    logic push;
    logic [2:0] occupancy;

    always_comb begin
        wr_ready   = !rst;
        wr_fire    = wr_valid & wr_ready;
        conflict   = wr_fire & rd_req_valid & (rd_req_addr == wr_addr);
        occupancy  = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
        rd_req_ready = !rst & !conflict & (occupancy < 3'd2);
        rd_fire    = rd_req_valid & rd_req_ready;

        // rd_valid is masked during reset so nothing leaves the buffer while it is being flushed
        fifo_empty = (fifo_cnt_q == 2'd0);
        rd_valid   = !rst & (!fifo_empty | inflight_q);
        rd_data    = fifo_empty ? sram_b_do : fifo_mem_q[rd_ptr_q];
        pop        = rd_valid & rd_ready;
        pop_fifo   = pop & !fifo_empty;
        push       = inflight_q & !(fifo_empty & pop);

        inflight_d  = rd_fire;
        fifo_cnt_d  = fifo_cnt_q + {1'b0, push} - {1'b0, pop_fifo};
        wr_ptr_d    = wr_ptr_q ^ push;
        rd_ptr_d    = rd_ptr_q ^ pop_fifo;
        fifo_mem_d  = fifo_mem_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = sram_b_do;
        end

        conflict_cnt_d = conflict_cnt_q;
        if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q     <= 1'b0;
            fifo_cnt_q     <= 2'd0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_mem_q[0]  <= '0;
            fifo_mem_q[1]  <= '0;
            conflict_cnt_q <= 16'd0;
        end else begin
            inflight_q     <= inflight_d;
            fifo_cnt_q     <= fifo_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_mem_q     <= fifo_mem_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Port A is write-only, port B is read-only
    assign sram_a_cs    = wr_fire;
    assign sram_a_wen   = !wr_fire;
    assign sram_a_addr  = wr_addr;
    assign sram_a_di    = wr_data;
    assign sram_a_oe    = 1'b0;

    assign sram_b_cs    = rd_fire;
    assign sram_b_wen   = 1'b1;
    assign sram_b_addr  = rd_req_addr;
    assign sram_b_di    = '0;
    assign sram_b_oe    = 1'b1;

    assign conflict_cnt = conflict_cnt_q;
    assign idle         = !inflight_q & (fifo_cnt_q == 2'd0);

endmodule

// File: tb/tb_inout_sram_port_ctrl.sv
// Testbench for inout_sram_port_ctrl: directed vector table plus randomized traffic
// checked against a transaction-level model (shadow memory + response queue).
module tb_inout_sram_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid, wr_ready;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_req_valid, rd_req_ready;
    logic [14:0] rd_req_addr;
    logic        rd_valid, rd_ready;
    logic [15:0] rd_data;
    logic [14:0] sram_a_addr, sram_b_addr;
    logic [15:0] sram_a_di, sram_b_di, sram_b_do;
    logic        sram_a_cs, sram_a_wen, sram_a_oe;
    logic        sram_b_cs, sram_b_wen, sram_b_oe;
    logic [15:0] conflict_cnt;
    logic        idle;

    int compared = 0;
    int mismatched = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    inout_sram_port_ctrl #(.ADDR_W(15), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .sram_a_addr(sram_a_addr), .sram_a_di(sram_a_di), .sram_a_cs(sram_a_cs),
        .sram_a_wen(sram_a_wen), .sram_a_oe(sram_a_oe),
        .sram_b_addr(sram_b_addr), .sram_b_di(sram_b_di), .sram_b_cs(sram_b_cs),
        .sram_b_wen(sram_b_wen), .sram_b_oe(sram_b_oe), .sram_b_do(sram_b_do),
        .conflict_cnt(conflict_cnt), .idle(idle)
    );

    function automatic logic [15:0] init_val(input int a);
        return 16'(a * 3 + 1);
    endfunction

    // SRAM macro stand-in: synchronous write on A, registered read on B
    logic [15:0] sram_mem [32768];
    logic [15:0] shadow   [32768];
    initial begin
        for (int i = 0; i < 32768; i++) begin
            sram_mem[i] = init_val(i);
            shadow[i]   = init_val(i);
        end
        sram_b_do = 16'h0;
    end

    always @(posedge clk) begin
        if (sram_a_cs && !sram_a_wen) sram_mem[sram_a_addr] <= sram_a_di;
        if (sram_b_cs) sram_b_do <= sram_mem[sram_b_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: accepted reads queue their expected data in order
    logic [15:0] resp_q [$];
    logic [15:0] cc_model = 16'd0;

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_conf, exp_rr, exp_wfire;
            exp_wfire = wr_valid && !rst;
            exp_conf  = exp_wfire && rd_req_valid && (rd_req_addr == wr_addr);
            exp_rr    = !rst && !exp_conf && (resp_q.size() < 2);
            check("mon_wr_ready", 32'(wr_ready), 32'(!rst));
            check("mon_rd_req_ready", 32'(rd_req_ready), 32'(exp_rr));
            check("mon_rd_valid", 32'(rd_valid), 32'(!rst && resp_q.size() > 0));
            check("mon_idle", 32'(idle), 32'(resp_q.size() == 0));
            check("mon_conflict_cnt", 32'(conflict_cnt), 32'(cc_model));
            check("mon_a_cs", 32'(sram_a_cs), 32'(exp_wfire));
            check("mon_a_wen", 32'(sram_a_wen), 32'(!exp_wfire));
            check("mon_a_oe", 32'(sram_a_oe), 32'd0);
            if (exp_wfire) begin
                check("mon_a_addr", 32'(sram_a_addr), 32'(wr_addr));
                check("mon_a_di", 32'(sram_a_di), 32'(wr_data));
            end
            check("mon_b_cs", 32'(sram_b_cs), 32'(rd_req_valid && exp_rr));
            check("mon_b_ctl", {sram_b_wen, sram_b_oe, sram_b_di}, {2'b11, 16'h0});
            if (rd_req_valid && exp_rr) check("mon_b_addr", 32'(sram_b_addr), 32'(rd_req_addr));
            if (!rst && rd_valid && rd_ready) begin
                if (resp_q.size() == 0) begin
                    check("mon_spurious_resp", 32'(rd_data), 32'hFFFF_FFFF);
                end else begin
                    check("mon_rd_data", 32'(rd_data), 32'(resp_q.pop_front()));
                end
            end
            if (rd_req_valid && exp_rr) resp_q.push_back(shadow[rd_req_addr]);
            if (exp_wfire) shadow[wr_addr] = wr_data;
            if (rst) begin
                cc_model = 16'd0;
                resp_q.delete();
            end else if (exp_conf && cc_model != 16'hFFFF) begin
                cc_model = cc_model + 16'd1;
            end
        end
    end

    typedef struct {
        logic        rst, wv;
        logic [14:0] wa;
        logic [15:0] wd;
        logic        rv;
        logic [14:0] ra;
        logic        rr;
        logic        e_wrr, e_rrdy, e_valid, chk_data;
        logic [15:0] e_data, e_cc;
        logic        e_idle;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic r, wv, input logic [14:0] wa, input logic [15:0] wd,
                       input logic rv, input logic [14:0] ra, input logic rr,
                       input logic e_wrr, e_rrdy, e_valid, chk, input logic [15:0] e_d,
                       input logic [15:0] e_cc, input logic e_idle);
        vec_t v;
        v = '{r, wv, wa, wd, rv, ra, rr, e_wrr, e_rrdy, e_valid, chk, e_d, e_cc, e_idle};
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic r, wv, input logic [14:0] wa, input logic [15:0] wd,
                                 input logic rv, input logic [14:0] ra, input logic rr);
        @(posedge clk);
        #1;
        rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_req_valid = rv; rd_req_addr = ra; rd_ready = rr;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        @(negedge clk);
        check($sformatf("vec%0d_wr_ready", idx), 32'(wr_ready), 32'(v.e_wrr));
        check($sformatf("vec%0d_rd_req_ready", idx), 32'(rd_req_ready), 32'(v.e_rrdy));
        check($sformatf("vec%0d_rd_valid", idx), 32'(rd_valid), 32'(v.e_valid));
        if (v.chk_data) check($sformatf("vec%0d_rd_data", idx), 32'(rd_data), 32'(v.e_data));
        check($sformatf("vec%0d_conflict_cnt", idx), 32'(conflict_cnt), 32'(v.e_cc));
        check($sformatf("vec%0d_idle", idx), 32'(idle), 32'(v.e_idle));
    endtask

    initial begin
        logic [15:0] e;
        rst = 1'b1; wr_valid = 0; wr_addr = 0; wr_data = 0;
        rd_req_valid = 0; rd_req_addr = 0; rd_ready = 0;
        repeat (2) @(posedge clk);

        //   rst wv wa  wd        rv ra  rr | wrr rrdy v chk data       cc  idle
        add(1, 0, 0,  16'h0,    0, 0,  0,   0, 0, 0, 0, 16'h0,    0,  1);
        add(0, 1, 5,  16'h1234, 0, 0,  0,   1, 1, 0, 0, 16'h0,    0,  1);
        add(0, 0, 0,  16'h0,    1, 5,  1,   1, 1, 0, 0, 16'h0,    0,  1);
        add(0, 0, 0,  16'h0,    0, 0,  1,   1, 1, 1, 1, 16'h1234, 0,  0);
        add(0, 0, 0,  16'h0,    0, 0,  1,   1, 1, 0, 0, 16'h0,    0,  1);
        for (int i = 0; i < 8; i++) begin
            e = (i - 1 == 5) ? 16'h1234 : init_val(i - 1);
            add(0, 0, 0, 16'h0, 1, 15'(i), 1, 1, 1, i > 0, i > 0, e, 0, i == 0);
        end
        add(0, 0, 0,  16'h0,    0, 0,  1,   1, 1, 1, 1, init_val(7), 0, 0);
        add(0, 0, 0,  16'h0,    1, 10, 0,   1, 1, 0, 0, 16'h0,    0,  1);
        add(0, 0, 0,  16'h0,    1, 11, 0,   1, 1, 1, 1, init_val(10), 0, 0);
        add(0, 0, 0,  16'h0,    1, 12, 0,   1, 0, 1, 1, init_val(10), 0, 0);
        add(0, 0, 0,  16'h0,    1, 12, 0,   1, 0, 1, 1, init_val(10), 0, 0);
        add(0, 0, 0,  16'h0,    1, 12, 1,   1, 0, 1, 1, init_val(10), 0, 0);
        add(0, 0, 0,  16'h0,    1, 12, 1,   1, 1, 1, 1, init_val(11), 0, 0);
        add(0, 0, 0,  16'h0,    0, 0,  1,   1, 1, 1, 1, init_val(12), 0, 0);
        add(0, 0, 0,  16'h0,    0, 0,  1,   1, 1, 0, 0, 16'h0,    0,  1);
        add(0, 1, 7,  16'h00AA, 0, 0,  1,   1, 1, 0, 0, 16'h0,    0,  1);
        add(0, 1, 7,  16'h00BB, 1, 7,  1,   1, 0, 0, 0, 16'h0,    0,  1);
        add(0, 0, 0,  16'h0,    1, 7,  1,   1, 1, 0, 0, 16'h0,    1,  1);
        add(0, 0, 0,  16'h0,    0, 0,  1,   1, 1, 1, 1, 16'h00BB, 1,  0);
        add(0, 1, 20, 16'h0C0C, 1, 21, 1,   1, 1, 0, 0, 16'h0,    1,  1);
        add(0, 0, 0,  16'h0,    0, 0,  1,   1, 1, 1, 1, init_val(21), 1, 0);
        add(0, 0, 0,  16'h0,    1, 30, 0,   1, 1, 0, 0, 16'h0,    1,  1);
        add(0, 0, 0,  16'h0,    1, 31, 0,   1, 1, 1, 1, init_val(30), 1, 0);
        add(0, 1, 40, 16'h1111, 1, 40, 0,   1, 0, 1, 1, init_val(30), 1, 0);
        add(1, 0, 0,  16'h0,    0, 0,  1,   0, 0, 0, 0, 16'h0,    2,  0);
        add(0, 0, 0,  16'h0,    0, 0,  1,   1, 1, 0, 0, 16'h0,    0,  1);
        add(0, 0, 0,  16'h0,    0, 0,  1,   1, 1, 0, 0, 16'h0,    0,  1);

        mon_en = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].wv, vecs[i].wa, vecs[i].wd,
                          vecs[i].rv, vecs[i].ra, vecs[i].rr);
            checkOutput(i, vecs[i]);
        end

        // Narrow address range so collisions and backpressure occur often
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                          15'($urandom_range(0, 7)), 16'($urandom),
                          1'($urandom_range(0, 1)), 15'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inout_sram_port_ctrl.md
# inout_sram_port_ctrl

Port controller directly upstream of the 32768x16 dual-port InOut activation SRAM. Turns a valid/ready write stream into port-A write strobes, and a valid/ready read-request stream into port-B reads. Port-B read data comes back as a backpressure-safe valid/ready stream through a 2-entry skid buffer. Blocks same-cycle same-address A-write/B-read collisions, which the macro resolves in favour of port A, and counts them.

## Interface
- ADDR_W, 15, word address width (32768 words)
- DATA_W, 16, data width
- clk  in  1  single clock; drives both SRAM ports (CKA = CKB = clk)
- rst  in  1  synchronous, active-high reset
- wr_valid / wr_ready  in / out  1  write-stream handshake
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_req_valid / rd_req_ready  in / out  1  read-request handshake
- rd_req_addr  in  ADDR_W  read address
- rd_valid / rd_ready  out / in  1  read-data handshake
- rd_data  out  DATA_W  read data, in request order
- sram_a_addr  out  ADDR_W  port-A address
- sram_a_di  out  DATA_W  port-A write data
- sram_a_cs, sram_a_wen, sram_a_oe  out  1  port-A chip select, write enable (active low), output enable
- sram_b_addr  out  ADDR_W  port-B address
- sram_b_di  out  DATA_W  port-B write data
- sram_b_cs, sram_b_wen, sram_b_oe  out  1  port-B chip select, write enable (active low), output enable
- sram_b_do  in  DATA_W  port-B read data, valid the cycle after sram_b_cs
- conflict_cnt  out  16  saturating count of cycles a read request was blocked by collision
- idle  out  1  no read in flight and skid buffer empty

## Operation
- Write path, combinational:
  - wr_ready = !rst
  - wr_fire = wr_valid & wr_ready
  - sram_a_cs = wr_fire; sram_a_wen = !wr_fire; sram_a_addr = wr_addr; sram_a_di = wr_data
  - sram_a_oe = 0 (port A is write-only)
- Read path:
  - Port B is read-only: sram_b_wen = 1, sram_b_di = 0, sram_b_oe = 1
  - sram_b_cs = rd_fire; sram_b_addr = rd_req_addr
- Collision: conflict = wr_fire & rd_req_valid & (rd_req_addr == wr_addr).
- Request acceptance:
  - rd_req_ready = !rst & !conflict & (fifo_cnt + inflight < 2)
  - rd_fire = rd_req_valid & rd_req_ready
- inflight register: set to rd_fire each cycle; marks sram_b_do as valid this cycle.
- Skid FIFO: 2 entries, fifo_cnt 0..2, pointers wrap at 2.
  - rd_valid = (fifo_cnt != 0) | inflight
  - rd_data = fifo head if fifo_cnt != 0, else sram_b_do (bypass)
  - pop = rd_valid & rd_ready
  - push = inflight & !(fifo_cnt == 0 & pop); pushes sram_b_do
  - Push and pop in the same cycle leave fifo_cnt unchanged.
- Ordering: responses leave strictly in request-acceptance order.
- conflict_cnt increments on each cycle conflict is high; saturates at 0xFFFF.
- idle = !inflight & (fifo_cnt == 0).

## Timing
- Reset values:
  - wr_ready = 0, rd_req_ready = 0, rd_valid = 0
  - sram_a_cs = sram_b_cs = 0; sram_a_wen = sram_b_wen = 1
  - inflight = 0, fifo_cnt = 0, conflict_cnt = 0, idle = 1
- Write latency: the memory is updated at the clock edge ending the wr_fire cycle. A read accepted in the next cycle returns the new data.
- Read latency: request accepted in cycle t → rd_valid in cycle t+1 (bypass). Sustained 1 read/cycle when rd_ready stays high.
- Backpressure:
  - With rd_ready low, at most 2 accepted reads are outstanding.
  - rd_req_ready stays low until pops free space.
  - No data loss; rd_data is stable while rd_valid & !rd_ready.
- Collision: the read request is held off one cycle. It is accepted the next cycle if no further collision, and then returns the written data.
- Reset asserted mid-operation: in-flight read and FIFO contents are discarded; nothing is emitted after reset.

## Test plan
- Write stream: write 0x1234 to addr 5, then read addr 5 next cycle → rd_valid at t+1, rd_data = 0x1234.
- Streaming reads: addrs 0..7 back-to-back with rd_ready = 1 → 8 responses on consecutive cycles, in order, rd_req_ready never low.
- Backpressure: issue reads to addrs 10, 11, 12 with rd_ready = 0:
  - rd_req_ready drops after 2 acceptances; fifo_cnt = 2
  - raise rd_ready → 10, 11, then 12 delivered in order, no duplicates
- Collision:
  - memory[7] = 0x00AA; same cycle: wr_fire to addr 7 with 0x00BB and rd_req_addr = 7
  - rd_req_ready = 0 that cycle; conflict_cnt = 1
  - read accepted next cycle and returns 0x00BB
  - a different-address simultaneous pair is accepted with no stall
- Reset mid-read: assert rst with fifo_cnt = 2 → next cycle rd_valid = 0, idle = 1, conflict_cnt = 0, no stale data emitted.
